// File: rtl/traffic_light_actuated_if.sv
// Signal bundle for the actuated traffic light controller.
// Optional pedestrian signals exist only when TLC_PED_EN is defined.
interface traffic_light_actuated_if;
   logic       side_sensor;
   logic [2:0] highway;
   logic [2:0] side_road;
   logic [2:0] phase;
`ifdef TLC_PED_EN
   logic       ped_req;
   logic       ped_walk;

   modport master (
      output side_sensor,
      output ped_req,
      input  highway,
      input  side_road,
      input  phase,
      input  ped_walk
   );

   modport slave (
      input  side_sensor,
      input  ped_req,
      output highway,
      output side_road,
      output phase,
      output ped_walk
   );
`else
   modport master (
      output side_sensor,
      input  highway,
      input  side_road,
      input  phase
   );

   modport slave (
      input  side_sensor,
      output highway,
      output side_road,
      output phase
   );
`endif
endinterface

// File: rtl/traffic_light_actuated.sv
// Actuated highway/side-road traffic light controller.
// Define TLC_PED_EN to add the pedestrian walk phase.
module traffic_light_actuated #(
   parameter int CNT_W        = 5,
   parameter int HW_MIN_GREEN = 8,
   parameter int YELLOW_T     = 2,
   parameter int ALLRED_T     = 1,
   parameter int SR_MIN_GREEN = 4,
   parameter int SR_MAX_GREEN = 8
`ifdef TLC_PED_EN
   ,
   parameter int PED_T        = 5
`endif
) (
   input logic clk,
   input logic rst,
   traffic_light_actuated_if.slave bus
);

   typedef enum logic [2:0] {
      INIT_RED  = 3'd0,
      HW_GREEN  = 3'd1,
      HW_YELLOW = 3'd2,
      ALL_RED1  = 3'd3,
      SR_GREEN  = 3'd4,
      SR_YELLOW = 3'd5,
      ALL_RED2  = 3'd6,
      PED_WALK  = 3'd7
   } state_t;

   localparam logic [2:0] RED    = 3'b100;
   localparam logic [2:0] YELLOW = 3'b010;
   localparam logic [2:0] GREEN  = 3'b001;

   localparam logic [CNT_W-1:0] AR_LAST  = CNT_W'(ALLRED_T - 1);
   localparam logic [CNT_W-1:0] Y_LAST   = CNT_W'(YELLOW_T - 1);
   localparam logic [CNT_W-1:0] HW_LAST  = CNT_W'(HW_MIN_GREEN - 1);
   localparam logic [CNT_W-1:0] SRN_LAST = CNT_W'(SR_MIN_GREEN - 1);
   localparam logic [CNT_W-1:0] SRX_LAST = CNT_W'(SR_MAX_GREEN - 1);
`ifdef TLC_PED_EN
   localparam logic [CNT_W-1:0] PED_LAST = CNT_W'(PED_T - 1);
`endif

   state_t           state;
   state_t           nxt;
   logic [CNT_W-1:0] cnt;
   logic             side_req;
   logic             req;
   logic [2:0]       hw_n;
   logic [2:0]       sr_n;

`ifdef TLC_PED_EN
   logic ped_lat;
   assign req = side_req | ped_lat;
`else
   assign req = side_req;
`endif

   always_comb begin
      nxt = state;
      case (state)
         INIT_RED:  if (cnt == AR_LAST) nxt = HW_GREEN;
         HW_GREEN:  if (cnt >= HW_LAST && req) nxt = HW_YELLOW;
         HW_YELLOW: if (cnt == Y_LAST) nxt = ALL_RED1;
         ALL_RED1:  if (cnt == AR_LAST) nxt = SR_GREEN;
         SR_GREEN: begin
            if ((cnt >= SRN_LAST && !bus.side_sensor) ||
                cnt == SRX_LAST)
               nxt = SR_YELLOW;
         end
         SR_YELLOW: if (cnt == Y_LAST) nxt = ALL_RED2;
`ifdef TLC_PED_EN
         ALL_RED2: begin
            if (cnt == AR_LAST)
               nxt = ped_lat ? PED_WALK : HW_GREEN;
         end
         PED_WALK:  if (cnt == PED_LAST) nxt = ALL_RED2;
`else
         ALL_RED2:  if (cnt == AR_LAST) nxt = HW_GREEN;
`endif
         default:   nxt = INIT_RED;
      endcase
   end

   // Lamps decode from the next state so they change with the state register.
   always_comb begin
      hw_n = RED;
      sr_n = RED;
      unique case (1'b1)
         nxt == HW_GREEN:  hw_n = GREEN;
         nxt == HW_YELLOW: hw_n = YELLOW;
         nxt == SR_GREEN:  sr_n = GREEN;
         nxt == SR_YELLOW: sr_n = YELLOW;
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state         <= INIT_RED;
         cnt           <= '0;
         side_req      <= 1'b0;
         bus.highway   <= RED;
         bus.side_road <= RED;
         bus.phase     <= 3'd0;
`ifdef TLC_PED_EN
         ped_lat       <= 1'b0;
         bus.ped_walk  <= 1'b0;
`endif
      end else begin
         state <= nxt;
         if (nxt != state)
            cnt <= '0;
         else if (cnt != '1)
            cnt <= cnt + 1'b1;
         // Clear on entry beats a same-cycle set.
         if (nxt == SR_GREEN && state != SR_GREEN)
            side_req <= 1'b0;
         else if (bus.side_sensor && state != SR_GREEN)
            side_req <= 1'b1;
`ifdef TLC_PED_EN
         if (nxt == PED_WALK && state != PED_WALK)
            ped_lat <= 1'b0;
         else if (bus.ped_req)
            ped_lat <= 1'b1;
         bus.ped_walk <= (nxt == PED_WALK);
`endif
         bus.highway   <= hw_n;
         bus.side_road <= sr_n;
         bus.phase     <= nxt;
      end
   end

endmodule

// File: tb/tb_traffic_light_actuated.sv
// Directed scoreboard bench for traffic_light_actuated.
// Pedestrian scenarios run only when TLC_PED_EN is defined.
module tb_traffic_light_actuated;

   logic clk = 1'b0;
   logic rst;

   always #5 clk = ~clk;

   traffic_light_actuated_if bus();

   traffic_light_actuated dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   typedef struct {
      logic [2:0] hw;
      logic [2:0] sr;
      logic [2:0] ph;
      logic       pw;
      string      tag;
   } exp_t;

   exp_t sbq[$];
   int checks = 0;
   int errors = 0;

   function automatic exp_t model(input logic [2:0] ph, input string tag);
      exp_t e;
      e.hw  = 3'b100;
      e.sr  = 3'b100;
      e.ph  = ph;
      e.pw  = (ph == 3'd7);
      e.tag = tag;
      case (ph)
         3'd1: e.hw = 3'b001;
         3'd2: e.hw = 3'b010;
         3'd4: e.sr = 3'b001;
         3'd5: e.sr = 3'b010;
         default: ;
      endcase
      return e;
   endfunction

   task automatic compare();
      exp_t       e;
      logic [9:0] obs;
      logic [9:0] expv;
      e = sbq.pop_front();
`ifdef TLC_PED_EN
      obs  = {bus.highway, bus.side_road, bus.phase, bus.ped_walk};
      expv = {e.hw, e.sr, e.ph, e.pw};
`else
      obs  = {bus.highway, bus.side_road, bus.phase, 1'b0};
      expv = {e.hw, e.sr, e.ph, 1'b0};
`endif
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s: observed %b expected %b", e.tag, obs, expv);
      end
   endtask

   task automatic now_chk(input logic [2:0] ph, input string tag);
      sbq.push_back(model(ph, tag));
      compare();
   endtask

   task automatic cyc(input logic [2:0] ph, input string tag);
      sbq.push_back(model(ph, tag));
      @(posedge clk);
      #1;
      compare();
   endtask

   task automatic run(input logic [2:0] ph, input int n, input string tag);
      for (int i = 0; i < n; i++) cyc(ph, tag);
   endtask

   task automatic side_phase(input int sr_len);
      run(3'd2, 2, "hw_yellow");
      run(3'd3, 1, "all_red1");
      run(3'd4, sr_len, "sr_green");
      run(3'd5, 2, "sr_yellow");
      run(3'd6, 1, "all_red2");
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog expired");
   end

   initial begin
      rst = 1'b1;
      bus.side_sensor = 1'b0;
`ifdef TLC_PED_EN
      bus.ped_req = 1'b0;
`endif
      #1 rst = 1'b0;
      #1 now_chk(3'd0, "reset_async");
      repeat (2) @(posedge clk);
      #1;
      now_chk(3'd0, "reset_held");
      rst = 1'b1;
      now_chk(3'd0, "init_red");
      run(3'd1, 100, "hw_hold_idle");

      // single-cycle sensor pulse while green is long past minimum
      bus.side_sensor = 1'b1;
      cyc(3'd1, "pulse_latch");
      bus.side_sensor = 1'b0;
      side_phase(4);
      cyc(3'd1, "hw_enter");
      run(3'd1, 3, "hw_cycles_1_3");
      bus.side_sensor = 1'b1;
      cyc(3'd1, "hw_cycle_4");
      bus.side_sensor = 1'b0;
      run(3'd1, 3, "hw_min_green");
      side_phase(4);
      run(3'd1, 12, "hw_after_clear");

      // sensor held: side green hits max, latch re-sets in yellow
      bus.side_sensor = 1'b1;
      cyc(3'd1, "held_latch");
      side_phase(8);
      run(3'd1, 8, "hw_relatched_min");
      bus.side_sensor = 1'b0;
      side_phase(4);
      run(3'd1, 10, "hw_hold_2");

      // asynchronous reset in the middle of side green
      bus.side_sensor = 1'b1;
      cyc(3'd1, "pre_reset_latch");
      bus.side_sensor = 1'b0;
      run(3'd2, 2, "hw_yellow");
      run(3'd3, 1, "all_red1");
      run(3'd4, 3, "sr_green_0_2");
      #3 rst = 1'b0;
      #1 now_chk(3'd0, "reset_mid_phase");
      @(posedge clk);
      #1;
      now_chk(3'd0, "reset_mid_held");
      rst = 1'b1;
      run(3'd1, 10, "restart_green");

`ifdef TLC_PED_EN
      bus.ped_req = 1'b1;
      cyc(3'd1, "ped_latch");
      bus.ped_req = 1'b0;
      side_phase(4);
      run(3'd7, 5, "ped_walk");
      run(3'd6, 1, "all_red2_post_ped");
      run(3'd1, 10, "hw_after_ped");

      bus.side_sensor = 1'b1;
      bus.ped_req = 1'b1;
      cyc(3'd1, "both_latch");
      bus.side_sensor = 1'b0;
      bus.ped_req = 1'b0;
      side_phase(4);
      run(3'd7, 5, "ped_walk_both");
      run(3'd6, 1, "all_red2_both");
      run(3'd1, 10, "hw_after_both");
`endif

      checks++;
      assert (sbq.size() == 0) else begin
         errors++;
         $error("FAIL scoreboard_drain: observed %0d expected 0", sbq.size());
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
